// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_BURST = 16;

  // Index width for n items, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating find-first-set: first asserted req_valid at or after rr_ptr, modulo N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req_valid,
  input  logic [IW-1:0] rr_ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IW'((32'(rr_ptr) + k) % N);
      if (!found && req_valid[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to let a winner hold the port for up to BURST_LEN words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned BURST_LEN  = 4,
  localparam int unsigned IW         = idx_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [IW-1:0]                 grant_id
);

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          grant_ok;
  logic [IW-1:0] grant_idx;
  logic          accept;

  logic unused_cfg;
  assign unused_cfg = (NUM_REQ > MAX_REQ) | (BURST_LEN > MAX_BURST);

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .found     (pick_found),
    .idx       (pick_idx)
  );

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned CW = idx_w(BURST_LEN + 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      state_q     <= ARB;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Grant selection, port steering and next-state.
  always_comb begin
    grant_idx = pick_idx;
    grant_ok  = pick_found;
    rr_ptr_d  = rr_ptr_q;
`ifdef FIFO_ARB_BURST_EN
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (state_q == HOLD) begin
      grant_idx = owner_q;
      grant_ok  = req_valid[owner_q];
    end
`endif

    accept    = grant_ok & ~full;
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
    wr       = accept;
    grant_id = grant_idx;
    wr_data  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (accept && grant_idx == IW'(i)) wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef FIFO_ARB_BURST_EN
    if (state_q == ARB) begin
      if (accept) begin
        rr_ptr_d = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
        if (BURST_LEN > 1) begin
          state_d     = HOLD;
          owner_d     = pick_idx;
          burst_cnt_d = CW'(1);
        end
      end
    end else if (!full) begin
      // Owner keeps the port until its burst ends or it runs dry.
      if (!req_valid[owner_q] || (burst_cnt_q + CW'(1) == CW'(BURST_LEN))) begin
        state_d     = ARB;
        burst_cnt_d = '0;
      end else begin
        burst_cnt_d = burst_cnt_q + CW'(1);
      end
    end
`else
    if (accept) begin
      rr_ptr_d = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
    end
`endif
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against a queue-based reference model.
// Honors FIFO_ARB_BURST_EN to select the expected burst behaviour.
module tb_fifo_wr_arbiter;

  localparam int NR     = 4;
  localparam int DW     = 8;
  localparam int BL     = 2;
  localparam int FDEPTH = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             full;
  logic             wr;
  logic [DW-1:0]    wr_data;
  logic [1:0]       grant_id;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full      (full),
    .wr        (wr),
    .wr_data   (wr_data),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Producer word queues (ring buffers) and reference model state.
  logic [7:0] pbuf [NR][256];
  int  head [NR];
  int  tail [NR];
  int  m_ptr, m_owner, m_cnt, fifo_cnt;
  bit  m_hold, rd_en, d_acc, run;
  int  d_id;
  logic [NR-1:0] exp_ready;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;
  exp_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic produce(input int p, input logic [7:0] v);
    pbuf[p][tail[p] % 256] = v;
    tail[p]++;
  endtask

  function automatic bit busy();
    for (int i = 0; i < NR; i++) if (head[i] != tail[i]) return 1'b1;
    return m_hold;
  endfunction

  // Present this cycle's inputs and work out what the arbiter must do.
  task automatic drive(input bit rd);
    exp_t e;
    rd_en = rd;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (head[i] != tail[i]);
      req_data[i*DW +: DW] = req_valid[i] ? pbuf[i][head[i] % 256] : 8'($urandom);
    end
    full  = (fifo_cnt == FDEPTH);
    d_acc = 1'b0;
    d_id  = 0;
    if (m_hold) begin
      d_id  = m_owner;
      d_acc = req_valid[m_owner] && !full;
    end else begin
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_ptr + k) % NR;
        if (req_valid[j]) begin
          d_id  = j;
          d_acc = !full;
          break;
        end
      end
    end
    exp_ready = '0;
    if (d_acc) begin
      exp_ready[d_id] = 1'b1;
      e.id   = 2'(d_id);
      e.data = pbuf[d_id][head[d_id] % 256];
      sb.push_back(e);
    end
  endtask

  // Apply the effects of the cycle that just ended at the rising edge.
  task automatic commit();
    bit rd_ok;
    rd_ok = rd_en && (fifo_cnt > 0);
    if (d_acc) begin
      head[d_id]++;
      if (!m_hold) begin
        m_ptr = (d_id + 1) % NR;
        if (BURST && BL > 1) begin
          m_hold  = 1'b1;
          m_owner = d_id;
          m_cnt   = 1;
        end
      end else begin
        m_cnt++;
        if (m_cnt == BL) begin
          m_hold = 1'b0;
          m_cnt  = 0;
        end
      end
    end else if (m_hold && !full && !req_valid[m_owner]) begin
      m_hold = 1'b0;
      m_cnt  = 0;
    end
    fifo_cnt = fifo_cnt + (d_acc ? 1 : 0) - (rd_ok ? 1 : 0);
  endtask

  task automatic step(input bit rd);
    drive(rd);
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy() && n < 100) begin
      step(1'b1);
      n++;
    end
    step(1'b1);
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL drain_timeout: producers still pending after %0d cycles", n);
    end
  endtask

  // Asynchronous reset in the middle of a cycle, valids dropped at the same moment.
  task automatic mid_reset();
    drive(1'b0);
    #2;
    reset     = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NR; i++) head[i] = tail[i];
    #1;
    chk("reset_ready", req_ready, 0);
    chk("reset_wr", wr, 0);
    sb.delete();
    d_acc     = 1'b0;
    exp_ready = '0;
    m_ptr     = 0;
    m_hold    = 1'b0;
    m_owner   = 0;
    m_cnt     = 0;
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (run && !reset) begin
        chk("req_ready", req_ready, exp_ready);
        chk("wr", wr, d_acc);
        if (wr === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wr: got id %0d data %0h, required no write", grant_id, wr_data);
          end else begin
            e = sb.pop_front();
            chk("grant_id", grant_id, e.id);
            chk("wr_data", wr_data, e.data);
          end
        end else begin
          chk("wr_data_idle", wr_data, 0);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    full      = 1'b0;
    run       = 1'b0;
    exp_ready = '0;
    d_acc     = 1'b0;
    d_id      = 0;
    rd_en     = 1'b0;
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_hold = 1'b0; fifo_cnt = 0;
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    #1;
    chk("por_ready", req_ready, 0);
    chk("por_wr", wr, 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    run = 1'b1;

    // Single producer 1, then probe that the pointer moved past it.
    produce(1, 8'h11);
    step(1'b1);
    step(1'b1);
    produce(0, 8'hA0);
    produce(2, 8'hA2);
    drain();

    // All four producers with a drained FIFO.
    for (int p = 0; p < NR; p++)
      for (int k = 0; k < 2; k++) produce(p, 8'(p * 16 + k + 8'h40));
    drain();

    // Producers 0 and 2 with long backlogs.
    for (int k = 0; k < 4; k++) begin
      produce(0, 8'(8'h80 + k));
      produce(2, 8'(8'hC0 + k));
    end
    drain();

    // Fill the FIFO until full, stall, then release one slot at a time.
    for (int p = 0; p < NR; p++)
      for (int k = 0; k < 3; k++) produce(p, 8'(8'h20 + p * 4 + k));
    for (int c = 0; c < 7; c++) step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    drain();

    // Reset while producer 2 owns the port; afterwards lowest index wins.
    for (int k = 0; k < 4; k++) produce(2, 8'(8'hD0 + k));
    step(1'b1);
    mid_reset();
    produce(1, 8'h31);
    produce(3, 8'h33);
    drain();

    // Owner 0 runs dry after one word while producer 3 waits.
    mid_reset();
    produce(0, 8'h50);
    produce(3, 8'h53);
    produce(3, 8'h54);
    drain();

    // Random traffic with random FIFO draining.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NR; p++)
        if ($urandom_range(99) < 30 && (tail[p] - head[p]) < 10) produce(p, 8'($urandom));
      step($urandom_range(2) != 0);
    end
    drain();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: %0d expected writes never seen, required 0", sb.size());
    end

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `FIFO` write port (`wr`, `wr_data`, `full`) between `NUM_REQ` producers. Each producer uses a valid/ready handshake; the arbiter picks one producer per cycle, steers its data onto the FIFO write port and back-pressures everyone while `full` is high. It sits directly in front of a `FIFO` instance, with its outputs wired to that FIFO's `wr`/`wr_data` and the FIFO's `full` fed back.

## Interface
- `NUM_REQ`, 4: number of producers, 2..8.
- `DATA_WIDTH`, 8: word width; matches the FIFO's `DATA_WIDTH`.
- `BURST_LEN`, 4: maximum consecutive writes held by one producer in burst mode, 1..16.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  producer i has a word.
- `req_data`  in  NUM_REQ*DATA_WIDTH  producer i's word in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot or zero; word i is accepted when `req_valid[i] & req_ready[i]`.
- `full`  in  1  from FIFO.
- `wr`  out  1  FIFO write strobe.
- `wr_data`  out  DATA_WIDTH  FIFO write data.
- `grant_id`  out  clog2(NUM_REQ)  index of the producer on the port; meaningful only when `wr`=1.

## Operation
- State: `rr_ptr` (search start index), FSM `ARB`/`HOLD`, `owner`, `burst_cnt` (clog2(BURST_LEN+1) bits).
- `ARB`: winner = first i with `req_valid[i]`=1, searching `rr_ptr`, `rr_ptr`+1, … modulo NUM_REQ. `req_ready[winner]` = ~`full`; all other ready bits are 0.
- `HOLD`: only `owner` is eligible. `req_ready[owner]` = ~`full`.
- Combinational outputs: `wr` = |(`req_valid` & `req_ready`); `wr_data` = `req_data` slice of the granted index; `grant_id` = granted index. When `wr`=0, `wr_data` is 0.
- On an accepted write in `ARB`: `rr_ptr` <= winner+1, wrapping NUM_REQ-1 to 0.
- `full`=1: no ready, no write, no state change. A `HOLD` owner keeps ownership across full stalls.
- No valid requester: `wr`=0 and state is unchanged.

## Timing
- Reset (asynchronous, immediate): `rr_ptr`=0, FSM=`ARB`, `owner`=0, `burst_cnt`=0. Outputs then follow combinationally: `req_ready`=0 and `wr`=0 while all valids are low.
- Latency 0: the word accepted in cycle N is written into the FIFO on the rising edge ending cycle N.
- `req_ready` may depend on `req_valid` and `full` in the same cycle. Producers must not make `req_valid` depend on `req_ready`.
- A producer holds `req_valid` and `req_data` stable until accepted.
- Reset mid-burst drops ownership. Words not yet accepted are the producers' responsibility.
- Simultaneous requests on all inputs: each producer is served within NUM_REQ grants (times BURST_LEN in burst mode).

## Configuration
- `FIFO_ARB_BURST_EN` defined: an accepted write in `ARB` with BURST_LEN>1 moves the FSM to `HOLD` with `owner`=winner and `burst_cnt`=1.
  - In `HOLD`, each accepted write increments `burst_cnt`.
  - The FSM returns to `ARB` when `burst_cnt` reaches BURST_LEN on an accept, or when the owner's `req_valid` is 0 in a cycle.
  - `rr_ptr` was already advanced past the owner on entry to `HOLD`.
- Undefined: the FSM stays in `ARB`, `HOLD`/`owner`/`burst_cnt` logic is removed, and the grant rotates after every accepted word. BURST_LEN is ignored.

## Structure
- Package `fifo_arb_pkg`:
  - state enum `arb_state_t` {`ARB`, `HOLD`};
  - `MAX_REQ`=8, `MAX_BURST`=16 constants;
  - index-width function `idx_w(n)`.
- Sub-module `rr_pick`: combinational find-first-set from a rotating start index. Inputs `req_valid` and `rr_ptr`; outputs `found` and `idx`. Instantiated once.

## Test plan
Bench: NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=2, driving a FIFO with ADDR_WIDTH=2.
- Single producer, non-burst: valid[1] with data 0x11 → `wr`=1, `wr_data`=0x11, `grant_id`=1 in the same cycle; `rr_ptr`=2 afterwards.
- All four valid, burst off, FIFO drained every cycle → grant order 0,1,2,3,0, one word per cycle.
- Burst on, valid[0] and valid[2] held high:
  - grants go 0,0,2,2,0,0;
  - the `HOLD` exit at `burst_cnt`=2 is checked.
- Fill FIFO with 4 words so `full`=1 → `req_ready`=0 and `wr`=0.
  - Issue one `rd` → `full` drops and the next round-robin producer is accepted that cycle.
  - The burst owner retains the grant across the stall.
- Owner drops valid after 1 word in `HOLD` → FSM returns to `ARB` next cycle and producer 3 (valid) is granted.
- Assert `reset` mid-burst → immediately `req_ready`=0 and `wr`=0 (all valids low). After release, the first grant goes to the lowest valid index ≥0.
